mdu_unit: RTL

//  Multiply/divide unit in EX stage; executes operations launched by the MDU control logic.

---
 rtl/mdu_pkg.sv | 31 +++
 rtl/mdu_unit_if.sv | 28 ++
 rtl/mdu_latency_timer.sv | 44 ++++
 rtl/mdu_unit.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mdu_pkg
//  Purpose  : Shared function codes, read selects and FSM state type for the
//             multiply/divide unit.
//  Revision : 1.0  initial release
// ============================================================================
package mdu_pkg;

  // IR_E[5:0] function codes handled (or recognised) by the MDU
  localparam logic [5:0] FUNC_MULT  = 6'b011000;
  localparam logic [5:0] FUNC_MULTU = 6'b011001;
  localparam logic [5:0] FUNC_DIV   = 6'b011010;
  localparam logic [5:0] FUNC_DIVU  = 6'b011011;
  localparam logic [5:0] FUNC_MTHI  = 6'b010001;
  localparam logic [5:0] FUNC_MTLO  = 6'b010011;
  localparam logic [5:0] FUNC_MFHI  = 6'b010000;
  localparam logic [5:0] FUNC_MFLO  = 6'b010010;

  // Read selects for the Out port
  localparam logic [1:0] READ_HI = 2'b01;
  localparam logic [1:0] READ_LO = 2'b10;

  // Operation sequencer states
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

endpackage : mdu_pkg
`default_nettype wire

// File: rtl/mdu_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : mdu_unit_if
//  Purpose  : Controller/operand bundle between EX stage and the MDU.
//  Revision : 1.0  initial release
// ============================================================================
interface mdu_unit_if;
  logic        Start;
  logic [5:0]  Func;
  logic [31:0] A;
  logic [31:0] B;
  logic [1:0]  Read;
  logic        Busy;
  logic [31:0] Out;

  // Pipeline / controller side
  modport master (
    output Start, Func, A, B, Read,
    input  Busy, Out
  );

  // MDU side
  modport slave (
    input  Start, Func, A, B, Read,
    output Busy, Out
  );
endinterface : mdu_unit_if
`default_nettype wire

// File: rtl/mdu_latency_timer.sv
`default_nettype none
// ============================================================================
//  Module   : mdu_latency_timer
//  Purpose  : Loadable down-counter that models operation latency. Busy rises
//             the cycle after a load and stays high load_val+1 cycles; done_o
//             flags the final busy cycle.
//  Revision : 1.0  initial release
// ============================================================================
module mdu_latency_timer #(
  parameter int CNT_W = 4
) (
  input  wire logic             clk,
  input  wire logic             reset_n,
  input  wire logic             load_i,
  input  wire logic [CNT_W-1:0] load_val_i,
  output logic                  busy_o,
  output logic                  done_o
);

  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;

  // Load when idle, then count down to zero and drop busy
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (load_i && !busy_q) begin
      cnt_q  <= load_val_i;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      if (cnt_q == '0) begin
        busy_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  assign busy_o = busy_q;
  assign done_o = busy_q && (cnt_q == '0);

endmodule : mdu_latency_timer
`default_nettype wire

// File: rtl/mdu_unit.sv
`default_nettype none
// ============================================================================
//  Module   : mdu_unit
//  Purpose  : EX-stage multiply/divide unit. Holds architectural HI/LO,
//             computes results at launch and commits them after a modelled
//             multi-cycle latency; serves mfhi/mflo reads combinationally.
//  Revision : 1.0  initial release
// ============================================================================
module mdu_unit
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  wire logic   clk,
  input  wire logic   reset_n,
  mdu_unit_if.slave   bus
);

  localparam int CNT_W = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  mdu_state_e  state_q, state_d;
  logic [31:0] hi_q, lo_q;
  logic [31:0] hi_tmp_q, lo_tmp_q;
  logic        pend_wr_q;

  logic        is_mult, is_div, is_signed_div;
  logic        launch, commit;
  logic        tmr_busy, tmr_done;
  logic [63:0] a_ext, b_ext, prod;
  logic [31:0] dvd, dvs, dvs_safe, uq, ur, quot, rem;
  logic [31:0] res_hi, res_lo;

  assign is_mult       = (bus.Func == FUNC_MULT) || (bus.Func == FUNC_MULTU);
  assign is_div        = (bus.Func == FUNC_DIV)  || (bus.Func == FUNC_DIVU);
  assign is_signed_div = (bus.Func == FUNC_DIV);

  // Result datapath: full product, and sign-magnitude division so the
  // most-negative / -1 case wraps to 0x80000000 without overflow.
  always_comb begin
    a_ext = (bus.Func == FUNC_MULT) ? {{32{bus.A[31]}}, bus.A} : {32'h0, bus.A};
    b_ext = (bus.Func == FUNC_MULT) ? {{32{bus.B[31]}}, bus.B} : {32'h0, bus.B};
    prod  = a_ext * b_ext;

    dvd      = (is_signed_div && bus.A[31]) ? (~bus.A + 32'd1) : bus.A;
    dvs      = (is_signed_div && bus.B[31]) ? (~bus.B + 32'd1) : bus.B;
    dvs_safe = (bus.B == 32'h0) ? 32'd1 : dvs;
    uq       = dvd / dvs_safe;
    ur       = dvd % dvs_safe;
    quot     = (is_signed_div && (bus.A[31] ^ bus.B[31])) ? (~uq + 32'd1) : uq;
    rem      = (is_signed_div && bus.A[31]) ? (~ur + 32'd1) : ur;

    res_hi = is_div ? rem  : prod[63:32];
    res_lo = is_div ? quot : prod[31:0];
  end

  // Sequencer state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: launch long ops from IDLE, return when the timer expires
  always_comb begin
    state_d = state_q;
    launch  = 1'b0;
    commit  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.Start && (is_mult || is_div)) begin
          launch  = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (tmr_done) begin
          commit  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  mdu_latency_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_i     (launch),
    .load_val_i (is_div ? DIV_LOAD : MULT_LOAD),
    .busy_o     (tmr_busy),
    .done_o     (tmr_done)
  );

  // Capture pending result at launch; divide-by-zero suppresses the commit
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hi_tmp_q  <= 32'h0;
      lo_tmp_q  <= 32'h0;
      pend_wr_q <= 1'b0;
    end else if (launch) begin
      hi_tmp_q  <= res_hi;
      lo_tmp_q  <= res_lo;
      pend_wr_q <= !(is_div && (bus.B == 32'h0));
    end
  end

  // Architectural HI/LO: commit at end of latency, or direct mthi/mtlo
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hi_q <= 32'h0;
      lo_q <= 32'h0;
    end else if (commit) begin
      if (pend_wr_q) begin
        hi_q <= hi_tmp_q;
        lo_q <= lo_tmp_q;
      end
    end else if ((state_q == ST_IDLE) && bus.Start) begin
      if (bus.Func == FUNC_MTHI) hi_q <= bus.A;
      if (bus.Func == FUNC_MTLO) lo_q <= bus.A;
    end
  end

  assign bus.Busy = tmr_busy;

  // Read port reflects committed registers only
  always_comb begin
    bus.Out = 32'h0;
    if (bus.Read == READ_HI)      bus.Out = hi_q;
    else if (bus.Read == READ_LO) bus.Out = lo_q;
  end

endmodule : mdu_unit
`default_nettype wire
